// File: rtl/vga_rx_capture.sv
// VGA receive-side capture. It measures the sync timing and locks onto the frame.
// Once locked, it recovers pixel coordinates and the one-hot color code from the RGB bus.
module vga_rx_capture #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BP        = 44,
  parameter int V_BP        = 31,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  R,
  input  logic [3:0]  G,
  input  logic [3:0]  B,
  output logic        pixel_valid,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [7:0]  color,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic        sync_err
);

  localparam int GW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;
  localparam logic [GW-1:0] LOCK_N  = GW'(LOCK_FRAMES);
  localparam logic [GW-1:0] ONE_G   = GW'(1);
  localparam logic [11:0]   H_TOT   = 12'(H_TOTAL);
  localparam logic [11:0]   V_TOT   = 12'(V_TOTAL);
  localparam logic [10:0]   H_LO    = 11'(H_BP);
  localparam logic [10:0]   H_HI    = 11'(H_BP + H_ACTIVE);
  localparam logic [10:0]   V_LO    = 11'(V_BP);
  localparam logic [10:0]   V_HI    = 11'(V_BP + V_ACTIVE);
  localparam logic [10:0]   CNT_MAX = 11'h7FF;

  // SEARCH | waiting for the first vsync rise
  // CHECK  | counting error-free frames toward lock
  // LOCKED | timing trusted, visible pixels are emitted
  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic          s1_vld_q, s1_vld_d;
  logic          s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
  logic          prev_hs_q, prev_hs_d, prev_vs_q, prev_vs_d;
  logic [11:0]   s1_rgb_q, s1_rgb_d;
  logic [10:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic          h_seen_q, h_seen_d, v_seen_q, v_seen_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [7:0]    color_q, color_d;
  logic          locked_q, locked_d;
  logic [10:0]   line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic          sync_err_q, sync_err_d;

  logic          hrise, vrise, err, in_win;
  logic [11:0]   h_sum, v_sum;

  function automatic logic [7:0] decode_color(input logic [11:0] rgb);
    case (rgb)
      12'h000: decode_color = 8'h01;
      12'h00F: decode_color = 8'h02;
      12'hB53: decode_color = 8'h04;
      12'h0BB: decode_color = 8'h08;
      12'hF00: decode_color = 8'h10;
      12'hB0B: decode_color = 8'h20;
      12'hFF0: decode_color = 8'h40;
      12'hFFF: decode_color = 8'h80;
      default: decode_color = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    good_d        = good_q;
    s1_vld_d      = pix_en;
    s1_hs_d       = s1_hs_q;
    s1_vs_d       = s1_vs_q;
    prev_hs_d     = prev_hs_q;
    prev_vs_d     = prev_vs_q;
    s1_rgb_d      = s1_rgb_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    h_seen_d      = h_seen_q;
    v_seen_d      = v_seen_q;
    pixel_valid_d = 1'b0;
    x_d           = x_q;
    y_d           = y_q;
    color_d       = color_q;
    locked_d      = locked_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    sync_err_d    = 1'b0;
    hrise         = 1'b0;
    vrise         = 1'b0;
    err           = 1'b0;
    in_win        = 1'b0;
    h_sum         = {1'b0, hcnt_q} + 12'd1;
    v_sum         = {1'b0, vcnt_q} + 12'd1;

    if (pix_en) begin
      prev_hs_d = s1_hs_q;
      prev_vs_d = s1_vs_q;
      s1_hs_d   = hsync;
      s1_vs_d   = vsync;
      s1_rgb_d  = {R, G, B};
    end

    // The sample captured on the previous strobe is processed exactly once here.
    if (s1_vld_q) begin
      hrise = s1_hs_q & ~prev_hs_q;
      vrise = s1_vs_q & ~prev_vs_q;

      if (hrise) begin
        hcnt_d     = '0;
        line_len_d = h_sum[10:0];
        h_seen_d   = 1'b1;
        if (h_seen_q && (h_sum != H_TOT)) err = 1'b1;
      end else if (hcnt_q != CNT_MAX) begin
        hcnt_d = hcnt_q + 11'd1;
        if (hcnt_q == CNT_MAX - 11'd1) err = 1'b1;
      end

      if (vrise) begin
        vcnt_d        = '0;
        frame_lines_d = v_sum[10:0];
        v_seen_d      = 1'b1;
        if (v_seen_q && (v_sum != V_TOT)) err = 1'b1;
      end else if (hrise && (vcnt_q != CNT_MAX)) begin
        vcnt_d = vcnt_q + 11'd1;
      end

      sync_err_d = err;

      case (state_q)
        SEARCH: begin
          if (vrise) begin
            state_d = CHECK;
            good_d  = '0;
          end
        end
        CHECK: begin
          if (err) begin
            state_d = SEARCH;
            good_d  = '0;
          end else if (vrise) begin
            if (good_q == LOCK_N - ONE_G) begin
              state_d = LOCKED;
              good_d  = LOCK_N;
            end else begin
              good_d = good_q + ONE_G;
            end
          end
        end
        LOCKED: begin
          if (err) begin
            state_d = SEARCH;
            good_d  = '0;
          end
        end
        default: begin
          state_d = SEARCH;
          good_d  = '0;
        end
      endcase

      locked_d = (state_d == LOCKED);
      in_win   = (state_d == LOCKED) &&
                 (hcnt_d >= H_LO) && (hcnt_d < H_HI) &&
                 (vcnt_d >= V_LO) && (vcnt_d < V_HI);
      if (in_win) begin
        pixel_valid_d = 1'b1;
        x_d           = 10'(hcnt_d - H_LO);
        y_d           = 10'(vcnt_d - V_LO);
        color_d       = decode_color(s1_rgb_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEARCH;
      good_q        <= '0;
      s1_vld_q      <= 1'b0;
      s1_hs_q       <= 1'b1;
      s1_vs_q       <= 1'b1;
      prev_hs_q     <= 1'b1;
      prev_vs_q     <= 1'b1;
      s1_rgb_q      <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      pixel_valid_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      color_q       <= '0;
      locked_q      <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_q        <= good_d;
      s1_vld_q      <= s1_vld_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      prev_hs_q     <= prev_hs_d;
      prev_vs_q     <= prev_vs_d;
      s1_rgb_q      <= s1_rgb_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      h_seen_q      <= h_seen_d;
      v_seen_q      <= v_seen_d;
      pixel_valid_q <= pixel_valid_d;
      x_q           <= x_d;
      y_q           <= y_d;
      color_q       <= color_d;
      locked_q      <= locked_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign pixel_valid = pixel_valid_q;
  assign x           = x_q;
  assign y           = y_q;
  assign color       = color_q;
  assign locked      = locked_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_rx_capture.sv
// Directed bench for vga_rx_capture on a reduced 20x12 raster with a 1-of-4 pixel strobe.
module tb_vga_rx_capture;
  localparam int HT = 20, VT = 12, HA = 8, VA = 6, HB = 4, VB = 3;
  localparam logic [11:0] RGB_TAB [9] = '{12'h000, 12'h00F, 12'hB53, 12'h0BB, 12'hF00,
                                          12'hB0B, 12'hFF0, 12'hFFF, 12'h123};
  localparam logic [7:0]  COL_TAB [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h00};

  logic        clk = 1'b0;
  logic        reset, pix_en, hsync, vsync;
  logic [3:0]  R, G, B;
  logic        pixel_valid, locked, sync_err;
  logic [9:0]  x, y;
  logic [7:0]  color;
  logic [10:0] line_len, frame_lines;

  int checks = 0;
  int errors = 0;
  int n_pv, n_err, n_bad, n_wide, first_err;
  logic        o_pv, o_err, o_lk, lk0, snap_err, snap_lk;
  logic [9:0]  o_x, o_y;
  logic [7:0]  o_col;
  logic [10:0] o_ll, snap_ll;

  always #5 clk = ~clk;

  vga_rx_capture #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_BP(HB), .V_BP(VB), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .R(R), .G(G), .B(B), .pixel_valid(pixel_valid), .x(x), .y(y), .color(color),
    .locked(locked), .line_len(line_len), .frame_lines(frame_lines), .sync_err(sync_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_pv = 0; n_err = 0; n_bad = 0;
  endtask

  // One strobe: drive, then look one cycle later (must be quiet), two cycles
  // later (result of this sample) and three cycles later (strobes gone again).
  task automatic strobe(input logic hs, input logic vs, input logic [11:0] rgb);
    @(negedge clk);
    pix_en = 1'b1; hsync = hs; vsync = vs; {R, G, B} = rgb;
    @(negedge clk);
    pix_en = 1'b0;
    if (pixel_valid || sync_err) n_wide++;
    @(negedge clk);
    o_pv = pixel_valid; o_err = sync_err; o_lk = locked;
    o_x = x; o_y = y; o_col = color; o_ll = line_len;
    if (o_err) n_err++;
    @(negedge clk);
    if (pixel_valid || sync_err) n_wide++;
  endtask

  function automatic int pix_idx(input int mode, input int h, input int v);
    if (mode == 0) return (h + v) % 9;
    if (v == VB) return 1;
    if (h == HB + HA - 1 && v == VB + VA - 1) return 7;
    return 0;
  endfunction

  task automatic gen_frame(input int mode, input bit exp_lock, input int short_v,
                           input int nlines, output logic first_lk);
    bit lk;
    bit vis;
    int idx;
    lk = exp_lock;
    first_lk = 1'bx;
    for (int v = 0; v < nlines; v++) begin
      for (int h = 0; h < HT; h++) begin
        if (v == short_v && h == HT - 3) continue;
        idx = pix_idx(mode, h, v);
        strobe(h < HT - 2, v < VT - 2, RGB_TAB[idx]);
        if (v == 0 && h == 0) first_lk = o_lk;
        if (short_v >= 0 && v == short_v + 1 && h == 0) begin
          lk = 1'b0; snap_err = o_err; snap_ll = o_ll; snap_lk = o_lk;
        end
        vis = lk && h >= HB && h < HB + HA && v >= VB && v < VB + VA;
        if (o_pv) begin
          n_pv++;
          if (!vis || o_x != 10'(h - HB) || o_y != 10'(v - VB) || o_col != COL_TAB[idx])
            n_bad++;
        end else if (vis) begin
          n_bad++;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; R = '0; G = '0; B = '0;
    n_wide = 0; first_err = -1; clr();
    repeat (3) @(negedge clk);
    check("rst_pv", pixel_valid, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_color", color, 0);
    check("rst_locked", locked, 0);
    check("rst_line_len", line_len, 0);
    check("rst_frame_lines", frame_lines, 0);
    check("rst_sync_err", sync_err, 0);
    reset = 1'b0;

    // Nominal lock: vsync #1 enters CHECK, #2 and #3 close good frames.
    strobe(1'b0, 1'b0, 12'h000);
    strobe(1'b0, 1'b0, 12'h000);
    clr();
    gen_frame(0, 1'b0, -1, VT, lk0);
    check("lock_f1", lk0, 0);
    gen_frame(0, 1'b0, -1, VT, lk0);
    check("lock_f2", lk0, 0);
    gen_frame(0, 1'b1, -1, VT, lk0);
    check("lock_f3", lk0, 1);
    check("nom_sync_err", n_err, 0);
    check("nom_line_len", line_len, HT);
    check("nom_frame_lines", frame_lines, VT);
    check("nom_pv_count", n_pv, HA * VA);
    check("palette_pixels", n_bad, 0);

    // Coordinates: row 0 all 00F, last visible pixel FFF.
    clr();
    gen_frame(1, 1'b1, -1, VT, lk0);
    check("coord_pv_count", n_pv, HA * VA);
    check("coord_pixels", n_bad, 0);
    check("coord_sync_err", n_err, 0);
    check("coord_last_x", x, HA - 1);
    check("coord_last_y", y, VA - 1);
    check("coord_last_color", color, 8'h80);

    // Short line at row 4: error lands on the hsync rise starting row 5.
    clr();
    gen_frame(0, 1'b1, 4, VT, lk0);
    check("short_err", snap_err, 1);
    check("short_line_len", snap_ll, HT - 1);
    check("short_locked", snap_lk, 0);
    check("short_err_count", n_err, 1);
    check("short_pv_count", n_pv, 2 * HA);
    check("short_pixels", n_bad, 0);
    clr();
    gen_frame(0, 1'b0, -1, VT, lk0);
    check("relock_v1", lk0, 0);
    gen_frame(0, 1'b0, -1, VT, lk0);
    check("relock_v2", lk0, 0);
    gen_frame(0, 1'b1, -1, VT, lk0);
    check("relock_v3", lk0, 1);
    check("relock_err_count", n_err, 0);
    check("relock_pv_count", n_pv, HA * VA);
    check("relock_pixels", n_bad, 0);

    // Lost hsync: first strobe is a normal line/frame start, then hcnt runs to 2047.
    clr();
    for (int i = 0; i < 2100; i++) begin
      strobe(1'b1, 1'b1, 12'hFFF);
      if (o_err && first_err < 0) first_err = i;
    end
    check("lost_err_count", n_err, 1);
    check("lost_err_index", first_err, 2047);
    check("lost_pv_count", n_pv, 0);
    check("lost_locked", locked, 0);
    check("lost_line_len", line_len, HT);

    // Reset mid-frame.
    strobe(1'b0, 1'b0, 12'h000);
    strobe(1'b0, 1'b0, 12'h000);
    gen_frame(0, 1'b0, -1, 6, lk0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_pv", pixel_valid, 0);
    check("mid_rst_x", x, 0);
    check("mid_rst_y", y, 0);
    check("mid_rst_color", color, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_line_len", line_len, 0);
    check("mid_rst_frame_lines", frame_lines, 0);
    check("mid_rst_sync_err", sync_err, 0);
    reset = 1'b0;
    clr();
    repeat (3) strobe(1'b1, 1'b1, 12'h000);
    repeat (2) strobe(1'b0, 1'b0, 12'h000);
    check("post_rst_no_edge_err", n_err, 0);
    check("post_rst_no_edge_ll", line_len, 0);
    check("post_rst_no_edge_fl", frame_lines, 0);
    strobe(1'b1, 1'b1, 12'h000);
    check("post_rst_first_err", o_err, 0);
    check("post_rst_first_ll", o_ll, 6);
    check("post_rst_first_fl", frame_lines, 1);

    check("strobe_width", n_wide, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
